// File: rtl/pwm_counter.sv
// pwm_counter: enable-gated free-running up counter with synchronous clear and terminal-count flag.
// Build option PWMCOUNTER_PWM_EN adds the Duty input and the PwmOut comparator output.
module pwm_counter #(
    parameter int unsigned WIDTH   = 26,
    parameter int unsigned MODULUS = 0
) (
    input  logic             Enable,
    input  logic             CLOCK_50,
    input  logic             Clear,
    output logic [WIDTH-1:0] CountValue,
    output logic             TermCount
`ifdef PWMCOUNTER_PWM_EN
    ,
    input  logic [WIDTH-1:0] Duty,
    output logic             PwmOut
`endif
);

    // MODULUS of 0 selects the full binary range of the counter.
    localparam logic [WIDTH-1:0] TERM = (MODULUS == 32'd0) ? {WIDTH{1'b1}}
                                                           : WIDTH'(MODULUS - 32'd1);

    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_q;
    logic             at_term_s;

    assign at_term_s = (count_q == TERM);

    // Next-count selection: advance and wrap at the terminal value, otherwise hold.
    always_comb begin
        count_d = count_q;
        if (Enable) begin
            if (at_term_s) begin
                count_d = {WIDTH{1'b0}};
            end else begin
                count_d = count_q + WIDTH'(1'b1);
            end
        end else begin
            count_d = count_q;
        end
    end

    // Count register; Clear wins over Enable on the same edge.
    always_ff @(posedge CLOCK_50) begin
        if (Clear) begin
            count_q <= {WIDTH{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign CountValue = count_q;
    assign TermCount  = at_term_s && Enable;

`ifdef PWMCOUNTER_PWM_EN
    assign PwmOut = (count_q < Duty);
`endif

endmodule

// File: tb/tb_pwm_counter.sv
// Randomized self-checking bench for pwm_counter: three parameterizations driven in lockstep
// and compared every cycle against a modular-arithmetic reference model.
module tb_pwm_counter;

    localparam longint MOD_BIG  = 64'd1 << 26;
    localparam longint MOD_MOD  = 64'd10;
    localparam longint MOD_FULL = 64'd16;

    logic        clk;
    logic        enable;
    logic        clear;
    logic [25:0] cnt_big;
    logic [3:0]  cnt_mod;
    logic [3:0]  cnt_full;
    logic        tc_big;
    logic        tc_mod;
    logic        tc_full;
`ifdef PWMCOUNTER_PWM_EN
    logic [25:0] duty_big;
    logic [3:0]  duty_mod;
    logic [3:0]  duty_full;
    logic        pwm_big;
    logic        pwm_mod;
    logic        pwm_full;
`endif

    longint m_big;
    longint m_mod;
    longint m_full;
    int     tests;
    int     fails;

    pwm_counter #(.WIDTH(26), .MODULUS(0)) u_big (
        .Enable(enable), .CLOCK_50(clk), .Clear(clear), .CountValue(cnt_big), .TermCount(tc_big)
`ifdef PWMCOUNTER_PWM_EN
        , .Duty(duty_big), .PwmOut(pwm_big)
`endif
    );

    pwm_counter #(.WIDTH(4), .MODULUS(10)) u_mod (
        .Enable(enable), .CLOCK_50(clk), .Clear(clear), .CountValue(cnt_mod), .TermCount(tc_mod)
`ifdef PWMCOUNTER_PWM_EN
        , .Duty(duty_mod), .PwmOut(pwm_mod)
`endif
    );

    pwm_counter #(.WIDTH(4), .MODULUS(0)) u_full (
        .Enable(enable), .CLOCK_50(clk), .Clear(clear), .CountValue(cnt_full), .TermCount(tc_full)
`ifdef PWMCOUNTER_PWM_EN
        , .Duty(duty_full), .PwmOut(pwm_full)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, advance the reference model, settle just after the edge.
    task automatic tick(input logic en, input logic clr);
        @(negedge clk);
        enable = en;
        clear  = clr;
        @(posedge clk);
        if (clr) begin
            m_big  = 0;
            m_mod  = 0;
            m_full = 0;
        end else if (en) begin
            m_big  = (m_big + 1) % MOD_BIG;
            m_mod  = (m_mod + 1) % MOD_MOD;
            m_full = (m_full + 1) % MOD_FULL;
        end
        #1;
    endtask

    task automatic test_reset;
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        tests++;
        if (cnt_big !== 26'd0 || cnt_mod !== 4'd0 || cnt_full !== 4'd0
            || tc_big !== 1'b0 || tc_mod !== 1'b0 || tc_full !== 1'b0) begin
            fails++;
            $display("FAIL reset: got big=%0d mod=%0d full=%0d tc=%b%b%b, want all 0",
                     cnt_big, cnt_mod, cnt_full, tc_big, tc_mod, tc_full);
        end
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b0);
            tests++;
            if (cnt_big !== 26'd0 || cnt_mod !== 4'd0 || cnt_full !== 4'd0) begin
                fails++;
                $display("FAIL reset_hold cycle %0d: got big=%0d mod=%0d full=%0d, want 0",
                         i, cnt_big, cnt_mod, cnt_full);
            end
        end
    endtask

    task automatic test_count_hold;
        int n;
        n = 20000;
        tick(1'b0, 1'b1);
        for (int i = 1; i <= n; i++) begin
            tick(1'b1, 1'b0);
            tests++;
            if (cnt_big !== 26'(m_big) || cnt_mod !== 4'(m_mod) || cnt_full !== 4'(m_full)
                || tc_mod !== (m_mod == MOD_MOD - 1) || tc_full !== (m_full == MOD_FULL - 1)
                || tc_big !== 1'b0) begin
                fails++;
                $display("FAIL count cycle %0d: got %0d/%0d/%0d tc=%b%b%b, want %0d/%0d/%0d",
                         i, cnt_big, cnt_mod, cnt_full, tc_big, tc_mod, tc_full,
                         m_big, m_mod, m_full);
            end
        end
        tests++;
        if (cnt_big !== 26'd20000) begin
            fails++;
            $display("FAIL count_total: got %0d, want 20000", cnt_big);
        end
        for (int i = 0; i < 100; i++) begin
            tick(1'b0, 1'b0);
            tests++;
            if (cnt_big !== 26'd20000 || cnt_mod !== 4'(20000 % 10) || cnt_full !== 4'(20000 % 16)
                || tc_mod !== 1'b0 || tc_full !== 1'b0) begin
                fails++;
                $display("FAIL hold cycle %0d: got %0d/%0d/%0d tc=%b%b, want 20000/0/0 tc=00",
                         i, cnt_big, cnt_mod, cnt_full, tc_mod, tc_full);
            end
        end
    endtask

    task automatic test_clear_priority;
        tick(1'b0, 1'b1);
        for (int i = 0; i < 1234; i++) tick(1'b1, 1'b0);
        tests++;
        if (cnt_big !== 26'd1234) begin
            fails++;
            $display("FAIL prio_preload: got %0d, want 1234", cnt_big);
        end
        tick(1'b1, 1'b1);
        tests++;
        if (cnt_big !== 26'd0 || cnt_mod !== 4'd0 || cnt_full !== 4'd0) begin
            fails++;
            $display("FAIL prio_clear: got %0d/%0d/%0d, want 0", cnt_big, cnt_mod, cnt_full);
        end
        for (int i = 1; i <= 5; i++) begin
            tick(1'b1, 1'b0);
            tests++;
            if (cnt_big !== 26'(i)) begin
                fails++;
                $display("FAIL prio_resume: got %0d, want %0d", cnt_big, i);
            end
        end
    endtask

    task automatic test_wrap;
        tick(1'b0, 1'b1);
        for (int i = 1; i <= 17; i++) begin
            tick(1'b1, 1'b0);
            tests++;
            if (cnt_mod !== 4'(i % 10) || tc_mod !== ((i % 10) == 9)
                || cnt_full !== 4'(i % 16) || tc_full !== ((i % 16) == 15)) begin
                fails++;
                $display("FAIL wrap step %0d: got mod=%0d tc=%b full=%0d tc=%b, want %0d/%b %0d/%b",
                         i, cnt_mod, tc_mod, cnt_full, tc_full,
                         i % 10, (i % 10) == 9, i % 16, (i % 16) == 15);
            end
        end
    endtask

    task automatic test_random;
        logic en;
        logic clr;
        for (int i = 0; i < 2000; i++) begin
            en  = 1'($urandom_range(0, 3) != 0);
            clr = 1'($urandom_range(0, 15) == 0);
            tick(en, clr);
            tests++;
            if (cnt_big !== 26'(m_big) || cnt_mod !== 4'(m_mod) || cnt_full !== 4'(m_full)
                || tc_mod !== ((m_mod == MOD_MOD - 1) && en)
                || tc_full !== ((m_full == MOD_FULL - 1) && en)
                || tc_big !== ((m_big == MOD_BIG - 1) && en)) begin
                fails++;
                $display("FAIL random %0d en=%b clr=%b: got %0d/%0d/%0d tc=%b%b%b, want %0d/%0d/%0d",
                         i, en, clr, cnt_big, cnt_mod, cnt_full, tc_big, tc_mod, tc_full,
                         m_big, m_mod, m_full);
            end
        end
    endtask

`ifdef PWMCOUNTER_PWM_EN
    task automatic test_pwm;
        logic [3:0] dm [4];
        dm[0] = 4'd3;
        dm[1] = 4'd0;
        dm[2] = 4'd15;
        dm[3] = 4'($urandom_range(0, 15));
        for (int k = 0; k < 4; k++) begin
            duty_mod  = dm[k];
            duty_full = dm[k];
            duty_big  = 26'(dm[k]);
            tick(1'b0, 1'b1);
            for (int i = 0; i < 25; i++) begin
                tick(1'b1, 1'b0);
                tests++;
                if (pwm_mod !== (m_mod < longint'(dm[k])) || pwm_full !== (m_full < longint'(dm[k]))
                    || pwm_big !== (m_big < longint'(dm[k]))) begin
                    fails++;
                    $display("FAIL pwm duty=%0d cnt=%0d: got %b%b%b, want %b%b%b", dm[k], m_mod,
                             pwm_big, pwm_mod, pwm_full, m_big < longint'(dm[k]),
                             m_mod < longint'(dm[k]), m_full < longint'(dm[k]));
                end
            end
        end
    endtask
`endif

    initial begin
        tests  = 0;
        fails  = 0;
        m_big  = 0;
        m_mod  = 0;
        m_full = 0;
        enable = 1'b0;
        clear  = 1'b1;
`ifdef PWMCOUNTER_PWM_EN
        duty_big  = 26'd0;
        duty_mod  = 4'd0;
        duty_full = 4'd0;
`endif
        test_reset();
        test_count_hold();
        test_clear_priority();
        test_wrap();
        test_random();
`ifdef PWMCOUNTER_PWM_EN
        test_pwm();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
